// File: rtl/mult_err_monitor.sv
// Error-characterisation monitor for approximate WxW multipliers: recomputes the
// exact product and accumulates error count, saturating ED sum and worst-case ED.
module mult_err_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       A,
  input  logic [W-1:0]       B,
  input  logic [2*W-1:0]     R,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [2*W-1:0]     max_ed,
  output logic [W-1:0]       max_a,
  output logic [W-1:0]       max_b
);

  localparam int PW = 2 * W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               vld_p1_q, vld_p1_d;
  logic               vld_p2_q, vld_p2_d;
  logic [W-1:0]       a_p1_q, a_p1_d;
  logic [W-1:0]       b_p1_q, b_p1_d;
  logic [PW-1:0]      r_p1_q, r_p1_d;
  logic [PW-1:0]      exact_p1_q, exact_p1_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [ACC_W-1:0]   sum_ed_q, sum_ed_d;
  logic [PW-1:0]      max_ed_q, max_ed_d;
  logic [W-1:0]       max_a_q, max_a_d;
  logic [W-1:0]       max_b_q, max_b_d;
  logic               accept;
  logic               clear;
  logic [PW-1:0]      ed_p2;

  function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] x, input logic [PW-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [PW-1:0]    inc);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + {{(ACC_W + 1 - PW){1'b0}}, inc};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    done_d      = done_q;
    remaining_d = remaining_q;
    clear       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clear = 1'b1;
          if (num_samples != '0) begin
            remaining_d = num_samples;
            in_ready_d  = 1'b1;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            state_d     = S_RUN;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            in_ready_d = 1'b0;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!vld_p1_q && !vld_p2_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 1: capture operands and form the exact product
  always_comb begin
    vld_p1_d   = accept;
    a_p1_d     = a_p1_q;
    b_p1_d     = b_p1_q;
    r_p1_d     = r_p1_q;
    exact_p1_d = exact_p1_q;
    if (accept) begin
      a_p1_d     = A;
      b_p1_d     = B;
      r_p1_d     = R;
      exact_p1_d = PW'(A) * PW'(B);
    end
  end

  // Stage 2: error distance folded into the running metrics
  assign ed_p2 = abs_diff(r_p1_q, exact_p1_q);

  always_comb begin
    vld_p2_d    = vld_p1_q;
    err_count_d = err_count_q;
    sum_ed_d    = sum_ed_q;
    max_ed_d    = max_ed_q;
    max_a_d     = max_a_q;
    max_b_d     = max_b_q;
    if (clear) begin
      err_count_d = '0;
      sum_ed_d    = '0;
      max_ed_d    = '0;
      max_a_d     = '0;
      max_b_d     = '0;
    end else if (vld_p1_q) begin
      if (ed_p2 != '0) err_count_d = err_count_q + CNT_W'(1);
      sum_ed_d = sat_add(sum_ed_q, ed_p2);
      // strict compare keeps the earliest sample on ties
      if (ed_p2 > max_ed_q) begin
        max_ed_d = ed_p2;
        max_a_d  = a_p1_q;
        max_b_d  = b_p1_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      err_count_q <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
      max_a_q     <= '0;
      max_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      err_count_q <= err_count_d;
      sum_ed_q    <= sum_ed_d;
      max_ed_q    <= max_ed_d;
      max_a_q     <= max_a_d;
      max_b_q     <= max_b_d;
    end
  end

  always_ff @(posedge clk) begin
    a_p1_q     <= a_p1_d;
    b_p1_q     <= b_p1_d;
    r_p1_q     <= r_p1_d;
    exact_p1_q <= exact_p1_d;
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_count_q;
  assign sum_ed    = sum_ed_q;
  assign max_ed    = max_ed_q;
  assign max_a     = max_a_q;
  assign max_b     = max_b_q;

endmodule

// File: tb/tb_mult_err_monitor.sv
// Bench for mult_err_monitor: two instances (ACC_W=32 and ACC_W=17) share stimulus,
// a transaction-level model predicts every output each cycle, plus literal checks.
module tb_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic [7:0]  A, B;
  logic [15:0] R;

  logic        in_ready0, busy0, done0, in_ready1, busy1, done1;
  logic [15:0] err0, err1, maxed0, maxed1;
  logic [31:0] sum0;
  logic [16:0] sum1;
  logic [7:0]  ma0, mb0, ma1, mb1;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mult_err_monitor #(.W(8), .CNT_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready0), .A(A), .B(B), .R(R),
    .busy(busy0), .done(done0), .err_count(err0), .sum_ed(sum0),
    .max_ed(maxed0), .max_a(ma0), .max_b(mb0)
  );

  mult_err_monitor #(.W(8), .CNT_W(16), .ACC_W(17)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready1), .A(A), .B(B), .R(R),
    .busy(busy1), .done(done1), .err_count(err1), .sum_ed(sum1),
    .max_ed(maxed1), .max_a(ma1), .max_b(mb1)
  );

  task automatic chk(input string nm, input longint got, input longint exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int a;
    int b;
    int r;
    int due;
  } samp_t;

  samp_t  pq[$];
  samp_t  s;
  bit     m_ready = 0, m_busy = 0, m_done = 0;
  int     m_rem = 0, m_err = 0, m_max = 0, m_ma = 0, m_mb = 0;
  longint m_sum = 0;
  int     m_edge = 0, done_at = -1, ed;
  bit     acc;

  function automatic longint sat(input longint v, input int bits);
    longint lim;
    lim = (longint'(1) << bits) - 1;
    return (v > lim) ? lim : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 0; m_busy = 0; m_done = 0; m_rem = 0;
      m_err = 0; m_sum = 0; m_max = 0; m_ma = 0; m_mb = 0;
      pq.delete(); done_at = -1;
    end else begin
      m_edge++;
      acc = in_valid && m_ready;
      while (pq.size() > 0 && pq[0].due == m_edge) begin
        s  = pq.pop_front();
        ed = s.r - s.a * s.b;
        if (ed < 0) ed = -ed;
        if (ed != 0) m_err++;
        m_sum += ed;
        if (ed > m_max) begin m_max = ed; m_ma = s.a; m_mb = s.b; end
      end
      if (acc) begin
        pq.push_back('{int'(A), int'(B), int'(R), m_edge + 1});
        m_rem--;
        if (m_rem == 0) begin m_ready = 0; done_at = m_edge + 3; end
      end else if (!m_busy && start) begin
        m_err = 0; m_sum = 0; m_max = 0; m_ma = 0; m_mb = 0;
        if (num_samples != 0) begin
          m_rem = int'(num_samples); m_ready = 1; m_busy = 1; m_done = 0;
        end else begin
          m_done = 1;
        end
      end
      if (m_edge == done_at) begin m_done = 1; m_busy = 0; end
    end
  end

  always @(negedge clk) begin
    chk("in_ready0", longint'(in_ready0), longint'(m_ready));
    chk("busy0", longint'(busy0), longint'(m_busy));
    chk("done0", longint'(done0), longint'(m_done));
    chk("err0", longint'(err0), longint'(m_err));
    chk("sum0", longint'(sum0), sat(m_sum, 32));
    chk("maxed0", longint'(maxed0), longint'(m_max));
    chk("max_a0", longint'(ma0), longint'(m_ma));
    chk("max_b0", longint'(mb0), longint'(m_mb));
    chk("in_ready1", longint'(in_ready1), longint'(m_ready));
    chk("busy1", longint'(busy1), longint'(m_busy));
    chk("done1", longint'(done1), longint'(m_done));
    chk("err1", longint'(err1), longint'(m_err));
    chk("sum1", longint'(sum1), sat(m_sum, 17));
    chk("maxed1", longint'(maxed1), longint'(m_max));
    chk("max_a1", longint'(ma1), longint'(m_ma));
    chk("max_b1", longint'(mb1), longint'(m_mb));
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input int n);
    start = 1'b1;
    num_samples = 16'(n);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic feed(input int a, input int b, input int r);
    bit rdy;
    int n;
    A = 8'(a); B = 8'(b); R = 16'(r); in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready0;
      @(posedge clk);
      n++;
    end while (!rdy && n < 20);
    if (!rdy) chk("feed_timeout", 0, 1);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done0 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  int lat;

  initial begin
    start = 0; num_samples = 0; in_valid = 0; A = 0; B = 0; R = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", longint'(in_ready0), 0);
    chk("rst_done", longint'(done0), 0);
    chk("rst_busy", longint'(busy0), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", longint'(in_ready0), 0);

    // exact products
    do_start(4);
    feed(3, 5, 15); feed(255, 255, 65025); feed(0, 7, 0); feed(16, 16, 256);
    in_valid = 0;
    wait_done(lat);
    chk("exact_lat", lat, 3);
    chk("exact_err", longint'(err0), 0);
    chk("exact_sum", longint'(sum0), 0);
    chk("exact_max", longint'(maxed0), 0);
    chk("exact_busy", longint'(busy0), 0);

    // mixed errors
    do_start(3);
    feed(3, 5, 14); feed(10, 10, 110); feed(7, 9, 60);
    in_valid = 0;
    wait_done(lat);
    chk("mixed_lat", lat, 3);
    chk("mixed_err", longint'(err0), 3);
    chk("mixed_sum", longint'(sum0), 14);
    chk("mixed_max", longint'(maxed0), 10);
    chk("mixed_a", longint'(ma0), 10);
    chk("mixed_b", longint'(mb0), 10);

    // tie and backpressure, extra in_valid left asserted
    do_start(2);
    feed(2, 2, 5);
    in_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    feed(1, 1, 2);
    A = 9; B = 9; R = 0;
    @(negedge clk);
    chk("tie_ready_drop", longint'(in_ready0), 0);
    wait_done(lat);
    repeat (2) @(posedge clk);
    #1;
    chk("tie_err", longint'(err0), 2);
    chk("tie_sum", longint'(sum0), 2);
    chk("tie_max", longint'(maxed0), 1);
    chk("tie_a", longint'(ma0), 2);
    chk("tie_b", longint'(mb0), 2);
    in_valid = 0;

    // saturation of the 17-bit accumulator
    do_start(3);
    feed(255, 255, 0); feed(255, 255, 0); feed(255, 255, 0);
    in_valid = 0;
    wait_done(lat);
    chk("sat_sum17", longint'(sum1), 131071);
    chk("sat_sum32", longint'(sum0), 195075);
    chk("sat_max", longint'(maxed1), 65025);
    chk("sat_err", longint'(err1), 3);

    // zero-length run clears results
    do_start(0);
    chk("zero_done", longint'(done0), 1);
    chk("zero_err", longint'(err0), 0);
    chk("zero_sum", longint'(sum1), 0);
    chk("zero_max", longint'(maxed0), 0);
    chk("zero_ready", longint'(in_ready0), 0);

    // start ignored mid-run
    do_start(2);
    feed(3, 5, 14);
    in_valid = 0;
    do_start(1);
    chk("ign_busy", longint'(busy0), 1);
    feed(10, 10, 110);
    in_valid = 0;
    wait_done(lat);
    chk("ign_err", longint'(err0), 2);
    chk("ign_sum", longint'(sum0), 11);
    chk("ign_max", longint'(maxed0), 10);

    // reset mid-run
    do_start(4);
    feed(3, 5, 14);
    in_valid = 0;
    @(posedge clk);
    #1;
    chk("pre_rst_err", longint'(err0), 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", longint'(in_ready0), 0);
    chk("mrst_busy", longint'(busy0), 0);
    chk("mrst_err", longint'(err0), 0);
    chk("mrst_sum", longint'(sum0), 0);
    chk("mrst_max", longint'(maxed0), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_ready", longint'(in_ready0), 0);
    chk("post_rst_done", longint'(done0), 0);
    do_start(3);
    feed(3, 5, 14); feed(10, 10, 110); feed(7, 9, 60);
    in_valid = 0;
    wait_done(lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_err", longint'(err0), 3);
    chk("post_rst_sum", longint'(sum0), 14);
    chk("post_rst_a", longint'(ma0), 10);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/mult_err_monitor.md
Name: mult_err_monitor

Overview:
- Downstream consumer of the approximate 8x8 multipliers: error-characterisation stage.
- Takes operand pairs A/B and the approximate product R produced by the multiplier under test, and recomputes the exact product internally.
- Accumulates error metrics over a programmed number of samples: error count, sum of error distance, maximum error distance, and the operands giving that maximum.
- Used in characterisation harnesses and on-chip self-test of each multiplier variant.

Parameters:
- W, 8, operand width; product width is 2W.
- CNT_W, 16, width of the sample and error counters.
- ACC_W, 32, width of the error-distance sum accumulator.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a measurement run.
- num_samples  in  CNT_W  samples to consume; sampled when start is accepted.
- in_valid  in  1  A/B/R valid.
- in_ready  out  1  block accepts a sample this cycle.
- A  in  W  multiplicand fed to the multiplier under test.
- B  in  W  multiplier operand.
- R  in  2W  approximate product from the multiplier under test.
- busy  out  1  run in progress.
- done  out  1  results valid; held until the next accepted start.
- err_count  out  CNT_W  samples with ED != 0.
- sum_ed  out  ACC_W  saturating sum of ED.
- max_ed  out  2W  largest ED seen.
- max_a  out  W  A of the max_ed sample.
- max_b  out  W  B of the max_ed sample.

Behaviour:
- Definitions:
  - ED = |R - A*B|, using the unsigned exact product (2W bits; no overflow).
  - Accept = in_valid && in_ready.
- Reset (async, rst_n=0): state IDLE; in_ready=0, busy=0, done=0; all result registers 0; pipeline valids 0. Reset mid-run discards the run entirely.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE:
  - in_ready=0.
  - start=1 with num_samples!=0: clear results, load remaining=num_samples, done<=0, busy<=1, go RUN.
  - start=1 with num_samples==0: clear results, go DONE (done=1 next cycle, all results 0).
- RUN:
  - in_ready=1 (registered, stays high while remaining!=0).
  - Each accept decrements remaining.
  - The accept that takes remaining 1->0 also drops in_ready on the next edge, then the block goes DRAIN.
  - start is ignored in RUN and DRAIN.
- Pipeline, 2 stages:
  - Stage 1 (accept edge): register A, B, R and compute exact=A*B.
  - Stage 2 (next edge): compute ED from the stage-1 registers and update the results:
    - err_count += (ED!=0);
    - sum_ed = min(sum_ed+ED, 2^ACC_W-1);
    - if ED > max_ed (strictly greater), update max_ed, max_a, max_b. Ties keep the earliest sample.
  - Back-to-back accepts are supported at 1 sample/cycle; in_valid gaps are allowed in RUN.
- DRAIN: wait until both stage valids are 0, then go DONE. done=1 and busy=0 are registered together on that edge.
- Latency: done rises exactly 3 edges after the accept edge of the final sample (stage1, stage2, done).
- Results:
  - Outputs update live during RUN and are stable while done=1.
  - done stays 1 until a start is accepted.
- Widths: err_count cannot overflow because it is bounded by num_samples.

Test Plan:
- Exact inputs: start, num_samples=4; samples (3,5,15), (255,255,65025), (0,7,0), (16,16,256) -> err_count=0, sum_ed=0, max_ed=0, max_a=0, max_b=0; done 3 cycles after the 4th accept.
- Mixed errors: num_samples=3; (3,5,14), (10,10,110), (7,9,60) -> ED 1, 10, 3; err_count=3, sum_ed=14, max_ed=10, max_a=10, max_b=10.
- Tie and backpressure: num_samples=2, in_valid toggling 1,0,0,1; (2,2,5) then (1,1,2), ED 1 and 1 -> max_a=2, max_b=2 (first kept); in_ready=0 after the 2nd accept; extra in_valid is not consumed.
- Saturation with ACC_W=17: num_samples=3, each (255,255,0), ED=65025 -> sum_ed=131071 (saturated), max_ed=65025, err_count=3.
- Zero run and start-ignore: start with num_samples=0 -> done=1 next cycle, all results 0, in_ready never 1. A start pulse mid-RUN does not restart or clear the run.
- Reset mid-run: rst_n low after 1 of 4 samples -> all outputs 0 immediately; after release the block is in IDLE with in_ready=0, and a new run gives correct results.
